bp_me_mem_cmd_assembler: RTL and testbench
==========================================

BP_ME_MEM_CMD_ASSEMBLER -- requirements
Module: bp_me_mem_cmd_assembler

Interface
REQ-001 Parameter paddr_width_p, default 40, physical address width.
REQ-002 Parameter data_width_p, default 64, payload width.
REQ-003 Parameter credits_p, default 8, maximum outstanding memory commands; credit counter width is clog2(credits_p+1).
REQ-004 clk_i  in  1  sole clock; all state on rising edge.
REQ-005 reset_n_i  in  1  reset, asynchronous assert, active-low.
REQ-006 hdr_v_i / hdr_ready_and_o  in/out  1/1  header channel valid/ready.
REQ-007 hdr_msg_type_i  in  4  bedrock mem message type: rd=0, wr=1, uc_rd=2, uc_wr=3.
REQ-008 hdr_addr_i  in  paddr_width_p  command address.
REQ-009 hdr_size_i  in  3  bedrock message size.
REQ-010 data_v_i / data_ready_and_o  in/out  1/1  payload channel valid/ready.
REQ-011 data_i  in  data_width_p  payload.
REQ-012 mem_cmd_v_o / mem_cmd_ready_and_i  out/in  1/1  assembled command valid/ready.
REQ-013 mem_cmd_msg_type_o, mem_cmd_addr_o, mem_cmd_size_o, mem_cmd_data_o  out  4/paddr_width_p/3/data_width_p  assembled command fields.
REQ-014 mem_resp_return_i  in  1  one memory response retired; returns one credit.
REQ-015 credits_o  out  clog2(credits_p+1)  available credits.
REQ-016 credit_overflow_o  out  1  sticky error flag.

Function
REQ-017 Payload-carrying types are exactly those in mem_cmd_payload_mask_gp: wr and uc_wr.
REQ-018 FSM states: e_ready, e_wait_data, e_send.
REQ-019 e_ready: hdr_ready_and_o = (credits_o != 0); no other handshake is active.
REQ-020 e_ready, header handshake: latch type/addr/size; go to e_wait_data if payload type, else e_send with latched data cleared to 0.
REQ-021 e_wait_data: data_ready_and_o = 1, hdr_ready_and_o = 0; on data handshake latch data_i and go to e_send.
REQ-022 e_send: mem_cmd_v_o = 1 with latched fields stable until handshake; on mem_cmd_ready_and_i go to e_ready.
REQ-023 mem_cmd_v_o, data_ready_and_o are 0 outside e_send and e_wait_data respectively.
REQ-024 Minimum latency: header-only command valid one cycle after header handshake; payload command valid one cycle after data handshake.
REQ-025 Throughput: at most one command per 2 cycles (header-only) or 3 cycles (payload); header is not accepted in the cycle of the send handshake.
REQ-026 Credit counter decrements by 1 on send handshake, increments by 1 on mem_resp_return_i; both in same cycle leave it unchanged.
REQ-027 mem_resp_return_i when counter equals credits_p and no send handshake: counter saturates, credit_overflow_o sets and stays 1 until reset.
REQ-028 Counter never decrements below 0 (guaranteed by REQ-019).
REQ-029 Data presented on data_i in e_ready or e_send is not consumed.

Reset
REQ-030 While reset_n_i = 0: state e_ready, credits_o = credits_p, credit_overflow_o = 0, latched fields 0, mem_cmd_v_o = 0, data_ready_and_o = 0.
REQ-031 hdr_ready_and_o = 1 in the first cycle after reset deasserts (credits_p > 0).
REQ-032 Reset asserted mid-transaction discards the in-progress command without emitting it and restores full credits.

Verification
REQ-033 Header rd, addr 0x80001000, size 3, ready held 1 -> next cycle mem_cmd_v_o=1, type 0, addr 0x80001000, data 0; credits_o 8 -> 7.
REQ-034 Header wr, data 0xDEADBEEF supplied 3 cycles later -> mem_cmd_v_o asserts the cycle after data handshake with data 0xDEADBEEF; hdr_ready_and_o=0 throughout wait.
REQ-035 8 rd commands, no returns -> credits_o=0, hdr_ready_and_o=0; one mem_resp_return_i -> credits_o=1, next header accepted.
REQ-036 Send handshake and mem_resp_return_i in same cycle at credits_o=5 -> credits_o stays 5.
REQ-037 mem_resp_return_i at credits_o=8 -> credits_o stays 8, credit_overflow_o=1 until reset.
REQ-038 Reset asserted in e_wait_data -> mem_cmd_v_o never asserts for that header, credits_o=8, state e_ready after release.

Source files
------------

// File: rtl/bp_me_mem_cmd_assembler.sv
// Joins a BedRock memory header and an optional payload beat into one memory
// command. Sending a command uses one credit, and each memory response returns one.
module bp_me_mem_cmd_assembler
  #(parameter int paddr_width_p = 40
   ,parameter int data_width_p  = 64
   ,parameter int credits_p     = 8
   ,localparam int credit_width_lp = $clog2(credits_p+1)
   )
   (input  logic                       clk_i
   ,input  logic                       reset_n_i

   ,input  logic                       hdr_v_i
   ,output logic                       hdr_ready_and_o
   ,input  logic [3:0]                 hdr_msg_type_i
   ,input  logic [paddr_width_p-1:0]   hdr_addr_i
   ,input  logic [2:0]                 hdr_size_i

   ,input  logic                       data_v_i
   ,output logic                       data_ready_and_o
   ,input  logic [data_width_p-1:0]    data_i

   ,output logic                       mem_cmd_v_o
   ,input  logic                       mem_cmd_ready_and_i
   ,output logic [3:0]                 mem_cmd_msg_type_o
   ,output logic [paddr_width_p-1:0]   mem_cmd_addr_o
   ,output logic [2:0]                 mem_cmd_size_o
   ,output logic [data_width_p-1:0]    mem_cmd_data_o

   ,input  logic                       mem_resp_return_i
   ,output logic [credit_width_lp-1:0] credits_o
   ,output logic                       credit_overflow_o
   );

   // Only wr (1) and uc_wr (3) carry a payload beat.
   localparam logic [15:0] mem_cmd_payload_mask_lp = 16'b0000_0000_0000_1010;
   localparam logic [credit_width_lp-1:0] credits_max_lp = credit_width_lp'(credits_p);

   typedef enum logic [1:0] {e_ready, e_wait_data, e_send} state_e;

   state_e                     state_q, state_d;
   logic [3:0]                 type_q, type_d;
   logic [paddr_width_p-1:0]   addr_q, addr_d;
   logic [2:0]                 size_q, size_d;
   logic [data_width_p-1:0]    data_q, data_d;
   logic [credit_width_lp-1:0] credits_q, credits_d;
   logic                       ovf_q, ovf_d;
   logic                       send_hs;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q   <= e_ready;
         type_q    <= '0;
         addr_q    <= '0;
         size_q    <= '0;
         data_q    <= '0;
         credits_q <= credits_max_lp;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         type_q    <= type_d;
         addr_q    <= addr_d;
         size_q    <= size_d;
         data_q    <= data_d;
         credits_q <= credits_d;
         ovf_q     <= ovf_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      type_d           = type_q;
      addr_d           = addr_q;
      size_d           = size_q;
      data_d           = data_q;
      hdr_ready_and_o  = 1'b0;
      data_ready_and_o = 1'b0;
      mem_cmd_v_o      = 1'b0;
      case (state_q)
         e_ready: begin
            // Accepting a header needs a free credit, so the counter cannot underflow.
            hdr_ready_and_o = (credits_q != '0);
            if (hdr_v_i && hdr_ready_and_o) begin
               type_d  = hdr_msg_type_i;
               addr_d  = hdr_addr_i;
               size_d  = hdr_size_i;
               data_d  = '0;
               state_d = mem_cmd_payload_mask_lp[hdr_msg_type_i] ? e_wait_data : e_send;
            end
         end
         e_wait_data: begin
            data_ready_and_o = 1'b1;
            if (data_v_i) begin
               data_d  = data_i;
               state_d = e_send;
            end
         end
         e_send: begin
            mem_cmd_v_o = 1'b1;
            if (mem_cmd_ready_and_i)
               state_d = e_ready;
         end
         default: state_d = e_ready;
      endcase
   end

   assign send_hs = mem_cmd_v_o & mem_cmd_ready_and_i;

   always_comb begin
      credits_d = credits_q;
      ovf_d     = ovf_q;
      if (send_hs && !mem_resp_return_i)
         credits_d = credits_q - 1'b1;
      else if (!send_hs && mem_resp_return_i) begin
         // A return with nothing outstanding is a protocol error: saturate and flag it.
         if (credits_q == credits_max_lp)
            ovf_d = 1'b1;
         else
            credits_d = credits_q + 1'b1;
      end
   end

   assign mem_cmd_msg_type_o = type_q;
   assign mem_cmd_addr_o     = addr_q;
   assign mem_cmd_size_o     = size_q;
   assign mem_cmd_data_o     = data_q;
   assign credits_o          = credits_q;
   assign credit_overflow_o  = ovf_q;

endmodule

// File: tb/tb_bp_me_mem_cmd_assembler.sv
// Bench for bp_me_mem_cmd_assembler: directed corner cases, then random traffic
// compared every cycle against a transaction-level model.
module tb_bp_me_mem_cmd_assembler;
   localparam int PW = 40, DW = 64, CR = 8, CW = $clog2(CR+1);

   logic          clk_i = 1'b0, reset_n_i;
   logic          hdr_v_i, hdr_ready_and_o;
   logic [3:0]    hdr_msg_type_i;
   logic [PW-1:0] hdr_addr_i;
   logic [2:0]    hdr_size_i;
   logic          data_v_i, data_ready_and_o;
   logic [DW-1:0] data_i;
   logic          mem_cmd_v_o, mem_cmd_ready_and_i;
   logic [3:0]    mem_cmd_msg_type_o;
   logic [PW-1:0] mem_cmd_addr_o;
   logic [2:0]    mem_cmd_size_o;
   logic [DW-1:0] mem_cmd_data_o;
   logic          mem_resp_return_i;
   logic [CW-1:0] credits_o;
   logic          credit_overflow_o;

   int errors = 0, checks = 0;

   bp_me_mem_cmd_assembler #(.paddr_width_p(PW), .data_width_p(DW), .credits_p(CR)) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i),
      .hdr_v_i(hdr_v_i), .hdr_ready_and_o(hdr_ready_and_o), .hdr_msg_type_i(hdr_msg_type_i),
      .hdr_addr_i(hdr_addr_i), .hdr_size_i(hdr_size_i),
      .data_v_i(data_v_i), .data_ready_and_o(data_ready_and_o), .data_i(data_i),
      .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_and_i(mem_cmd_ready_and_i),
      .mem_cmd_msg_type_o(mem_cmd_msg_type_o), .mem_cmd_addr_o(mem_cmd_addr_o),
      .mem_cmd_size_o(mem_cmd_size_o), .mem_cmd_data_o(mem_cmd_data_o),
      .mem_resp_return_i(mem_resp_return_i), .credits_o(credits_o),
      .credit_overflow_o(credit_overflow_o));

   always #5 clk_i = ~clk_i;

   // Model: at most one pending command, plus whether its payload is still owed.
   logic          m_have_hdr, m_need_data, m_have_data, m_ovf;
   logic [3:0]    m_type;
   logic [PW-1:0] m_addr;
   logic [2:0]    m_size;
   logic [DW-1:0] m_data;
   int            m_credits;

   function automatic logic m_hdr_ready();  return !m_have_hdr && m_credits != 0; endfunction
   function automatic logic m_data_ready(); return m_have_hdr && m_need_data && !m_have_data; endfunction
   function automatic logic m_cmd_v();      return m_have_hdr && (!m_need_data || m_have_data); endfunction

   task automatic model_reset();
      m_have_hdr = 0; m_need_data = 0; m_have_data = 0; m_ovf = 0;
      m_type = '0; m_addr = '0; m_size = '0; m_data = '0; m_credits = CR;
   endtask

   task automatic model_step();
      logic hs_hdr, hs_data, hs_send;
      hs_hdr  = hdr_v_i && m_hdr_ready();
      hs_data = data_v_i && m_data_ready();
      hs_send = m_cmd_v() && mem_cmd_ready_and_i;
      if (hs_send && !mem_resp_return_i) m_credits--;
      if (!hs_send && mem_resp_return_i) begin
         if (m_credits == CR) m_ovf = 1; else m_credits++;
      end
      if (hs_send) m_have_hdr = 0;
      if (hs_hdr) begin
         m_have_hdr = 1; m_have_data = 0; m_data = '0;
         m_need_data = (hdr_msg_type_i == 4'd1) || (hdr_msg_type_i == 4'd3);
         m_type = hdr_msg_type_i; m_addr = hdr_addr_i; m_size = hdr_size_i;
      end
      if (hs_data) begin m_data = data_i; m_have_data = 1; end
   endtask

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("hdr_ready", 64'(hdr_ready_and_o), 64'(m_hdr_ready()));
      chk("data_ready", 64'(data_ready_and_o), 64'(m_data_ready()));
      chk("cmd_v", 64'(mem_cmd_v_o), 64'(m_cmd_v()));
      chk("credits", 64'(credits_o), 64'(m_credits));
      chk("overflow", 64'(credit_overflow_o), 64'(m_ovf));
      if (m_cmd_v()) begin
         chk("cmd_type", 64'(mem_cmd_msg_type_o), 64'(m_type));
         chk("cmd_addr", 64'(mem_cmd_addr_o), 64'(m_addr));
         chk("cmd_size", 64'(mem_cmd_size_o), 64'(m_size));
         chk("cmd_data", 64'(mem_cmd_data_o), 64'(m_data));
      end
   endtask

   // Inputs are driven just after a falling edge; outputs checked there too.
   task automatic cyc();
      compare_all();
      @(posedge clk_i);
      model_step();
      @(negedge clk_i);
   endtask

   task automatic idle();
      hdr_v_i = 0; data_v_i = 0; mem_cmd_ready_and_i = 0; mem_resp_return_i = 0;
   endtask

   task automatic hdr(input logic [3:0] t, input logic [PW-1:0] a);
      hdr_v_i = 1; hdr_msg_type_i = t; hdr_addr_i = a; hdr_size_i = 3'd3;
   endtask

   task automatic do_reset();
      reset_n_i = 0; idle(); model_reset();
      #1;
      @(negedge clk_i);
      reset_n_i = 1;
   endtask

   initial begin
      idle(); data_i = '0; hdr_msg_type_i = '0; hdr_addr_i = '0; hdr_size_i = '0;
      reset_n_i = 0; model_reset();
      @(negedge clk_i); @(negedge clk_i);
      // Reset state
      chk("rst_credits", 64'(credits_o), 64'd8);
      chk("rst_ovf", 64'(credit_overflow_o), 64'd0);
      chk("rst_cmd_v", 64'(mem_cmd_v_o), 64'd0);
      chk("rst_data_ready", 64'(data_ready_and_o), 64'd0);
      chk("rst_addr", 64'(mem_cmd_addr_o), 64'd0);
      chk("rst_data", 64'(mem_cmd_data_o), 64'd0);
      reset_n_i = 1;
      chk("post_rst_hdr_ready", 64'(hdr_ready_and_o), 64'd1);

      // Header-only read, valid the next cycle
      mem_cmd_ready_and_i = 1; hdr(4'd0, 40'h0080001000); cyc(); hdr_v_i = 0;
      chk("rd_cmd_v", 64'(mem_cmd_v_o), 64'd1);
      chk("rd_type", 64'(mem_cmd_msg_type_o), 64'd0);
      chk("rd_addr", 64'(mem_cmd_addr_o), 64'h80001000);
      chk("rd_size", 64'(mem_cmd_size_o), 64'd3);
      chk("rd_data", 64'(mem_cmd_data_o), 64'd0);
      chk("rd_hdr_blocked", 64'(hdr_ready_and_o), 64'd0);
      cyc();
      chk("rd_credits", 64'(credits_o), 64'd7);

      // Write whose payload arrives 3 cycles later
      hdr(4'd1, 40'h0080002000); cyc(); hdr_v_i = 0;
      for (int i = 0; i < 3; i++) begin
         chk("wr_wait_hdr_ready", 64'(hdr_ready_and_o), 64'd0);
         chk("wr_wait_cmd_v", 64'(mem_cmd_v_o), 64'd0);
         cyc();
      end
      data_v_i = 1; data_i = 64'hDEADBEEF;
      chk("wr_data_ready", 64'(data_ready_and_o), 64'd1);
      cyc(); data_v_i = 0;
      chk("wr_cmd_v", 64'(mem_cmd_v_o), 64'd1);
      chk("wr_data", 64'(mem_cmd_data_o), 64'hDEADBEEF);
      cyc();
      chk("wr_credits", 64'(credits_o), 64'd6);

      // Send and return in the same cycle at 5 credits
      hdr(4'd2, 40'h10); cyc(); hdr_v_i = 0; cyc();
      chk("five_credits", 64'(credits_o), 64'd5);
      hdr(4'd0, 40'h20); cyc(); hdr_v_i = 0;
      mem_resp_return_i = 1; cyc(); mem_resp_return_i = 0;
      chk("same_cycle_credits", 64'(credits_o), 64'd5);

      // Credit exhaustion and recovery
      do_reset(); mem_cmd_ready_and_i = 1;
      for (int i = 0; i < 8; i++) begin hdr(4'd0, PW'(i*64)); cyc(); hdr_v_i = 0; cyc(); end
      chk("exhaust_credits", 64'(credits_o), 64'd0);
      hdr(4'd0, 40'h999);
      chk("exhaust_hdr_ready", 64'(hdr_ready_and_o), 64'd0);
      cyc();
      chk("exhaust_no_cmd", 64'(mem_cmd_v_o), 64'd0);
      hdr_v_i = 0; mem_resp_return_i = 1; cyc(); mem_resp_return_i = 0;
      chk("return_credits", 64'(credits_o), 64'd1);
      chk("return_hdr_ready", 64'(hdr_ready_and_o), 64'd1);
      hdr(4'd0, 40'h999); cyc(); hdr_v_i = 0;
      chk("return_cmd_v", 64'(mem_cmd_v_o), 64'd1);
      chk("return_cmd_addr", 64'(mem_cmd_addr_o), 64'h999);

      // Overflow is sticky until reset
      do_reset();
      mem_resp_return_i = 1; cyc(); mem_resp_return_i = 0;
      chk("ovf_credits", 64'(credits_o), 64'd8);
      chk("ovf_set", 64'(credit_overflow_o), 64'd1);
      for (int i = 0; i < 3; i++) cyc();
      chk("ovf_sticky", 64'(credit_overflow_o), 64'd1);
      do_reset();
      chk("ovf_cleared", 64'(credit_overflow_o), 64'd0);

      // Reset while waiting for payload discards the command
      hdr(4'd3, 40'h5555); cyc(); hdr_v_i = 0; cyc();
      chk("midrst_waiting", 64'(data_ready_and_o), 64'd1);
      do_reset(); mem_cmd_ready_and_i = 1; data_v_i = 1; data_i = 64'h1234;
      for (int i = 0; i < 3; i++) begin
         chk("midrst_no_cmd", 64'(mem_cmd_v_o), 64'd0);
         chk("midrst_hdr_ready", 64'(hdr_ready_and_o), 64'd1);
         chk("midrst_credits", 64'(credits_o), 64'd8);
         cyc();
      end
      data_v_i = 0;

      // Random traffic
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
            continue;
         end
         hdr_v_i             = ($urandom_range(0, 2) != 0);
         hdr_msg_type_i      = 4'($urandom_range(0, 5));
         hdr_addr_i          = PW'({$urandom(), $urandom()});
         hdr_size_i          = 3'($urandom_range(0, 7));
         data_v_i            = ($urandom_range(0, 1) != 0);
         data_i              = {$urandom(), $urandom()};
         mem_cmd_ready_and_i = ($urandom_range(0, 2) != 0);
         mem_resp_return_i   = ($urandom_range(0, 3) == 0);
         cyc();
      end
      idle();
      cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
